// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  r0_req;
    logic                  r0_write;
    logic                  r0_lock;
    logic [31:0]           r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;
    logic                  r0_err;

    logic                  r1_req;
    logic                  r1_write;
    logic                  r1_lock;
    logic [31:0]           r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;
    logic                  r1_err;

    logic                  mem_write;
    logic                  mem_read;
    logic [31:0]           mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  r0_req, r0_write, r0_lock, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_write, r1_lock, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output mem_write, mem_read, mem_address, mem_write_data,
        input  mem_read_data
    );

    // Requester/memory side
    modport master (
        output r0_req, r0_write, r0_lock, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_write, r1_lock, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  mem_write, mem_read, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter for a single-port data memory, with an
// owner lock for atomic sequences, alignment checking and a registered
// one-cycle response per granted access.
module data_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    lock_state_e           state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  prio_q, prio_d;
    logic [CW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    logic [1:0]            req, wr, lk, elig, gnt;
    logic [31:0]           addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic                  win, any_gnt, aligned;

    assign req      = {bus.r1_req,   bus.r0_req};
    assign wr       = {bus.r1_write, bus.r0_write};
    assign lk       = {bus.r1_lock,  bus.r0_lock};
    assign addr[0]  = bus.r0_addr;
    assign addr[1]  = bus.r1_addr;
    assign wdata[0] = bus.r0_wdata;
    assign wdata[1] = bus.r1_wdata;

    // Eligibility and winner selection: a lone eligible port wins, ties go to prio_q
    always_comb begin
        elig[0] = req[0] & ((state_q == UNLOCKED) | (owner_q == 1'b0));
        elig[1] = req[1] & ((state_q == UNLOCKED) | (owner_q == 1'b1));
        any_gnt = |elig;
        win     = (&elig) ? prio_q : elig[1];
        gnt     = '0;
        if (any_gnt) begin
            gnt[win] = 1'b1;
        end
        aligned = (addr[win][1:0] == 2'b00);
    end

    // Drive the memory only for an aligned granted access
    always_comb begin
        bus.mem_write      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        if (any_gnt && aligned) begin
            bus.mem_write      = wr[win];
            bus.mem_read       = ~wr[win];
            bus.mem_address    = addr[win];
            bus.mem_write_data = wdata[win];
        end
    end

    // Next-state: response pulses, round-robin priority and lock FSM with idle timeout
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        idle_cnt_d = idle_cnt_q;
        rvalid_d   = '0;
        err_d      = '0;
        rdata_d[0] = '0;
        rdata_d[1] = '0;

        if (any_gnt) begin
            if (aligned) begin
                rvalid_d[win] = 1'b1;
                if (!wr[win]) begin
                    rdata_d[win] = bus.mem_read_data;
                end
            end else begin
                err_d[win] = 1'b1;
            end
        end

        case (state_q)
            UNLOCKED: begin
                if (any_gnt) begin
                    prio_d = ~win;
                    if (aligned && lk[win]) begin
                        state_d    = LOCKED;
                        owner_d    = win;
                        idle_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                // Only the owner can be granted here; an aligned unlocking access releases
                if (any_gnt && aligned && !lk[win]) begin
                    state_d    = UNLOCKED;
                    prio_d     = ~owner_q;
                    idle_cnt_d = '0;
                end else if (req[owner_q]) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d    = UNLOCKED;
                    prio_d     = ~owner_q;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            idle_cnt_q <= '0;
            rvalid_q   <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            idle_cnt_q <= idle_cnt_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign bus.r0_gnt    = gnt[0];
    assign bus.r1_gnt    = gnt[1];
    assign bus.r0_rvalid = rvalid_q[0];
    assign bus.r1_rvalid = rvalid_q[1];
    assign bus.r0_err    = err_q[0];
    assign bus.r1_err    = err_q[1];
    assign bus.r0_rdata  = rdata_q[0];
    assign bus.r1_rdata  = rdata_q[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    data_mem_arbiter #(.DATA_WIDTH(DW), .LOCK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural memory: combinational read, write at posedge
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.mem_write) begin
            mem[bus.mem_address[9:2]] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = mem[bus.mem_address[9:2]];

    // Requester stimulus
    bit          t_req [2];
    bit          t_wr  [2];
    bit          t_lk  [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];

    // Reference model state
    logic [31:0] ref_mem [256];
    bit          m_locked;
    int          m_owner, m_prio, m_idle;
    bit          obs_g0, obs_g1, obs_mw;
    int          last_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setp(input int n, input bit rq, input bit wr, input bit lk,
                        input logic [31:0] a, input logic [31:0] d);
        t_req[n] = rq; t_wr[n] = wr; t_lk[n] = lk; t_addr[n] = a; t_wdata[n] = d;
    endtask

    task automatic apply();
        bus.r0_req = t_req[0]; bus.r0_write = t_wr[0]; bus.r0_lock = t_lk[0];
        bus.r0_addr = t_addr[0]; bus.r0_wdata = t_wdata[0];
        bus.r1_req = t_req[1]; bus.r1_write = t_wr[1]; bus.r1_lock = t_lk[1];
        bus.r1_addr = t_addr[1]; bus.r1_wdata = t_wdata[1];
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs
    task automatic step();
        int          win;
        bit          el0, el1, al, w_w, lk_w, acc;
        logic [31:0] a_w, d_w;
        bit          e_rv [2];
        bit          e_er [2];
        logic [31:0] e_rd [2];
        apply();
        #1;
        el0 = t_req[0] && (!m_locked || m_owner == 0);
        el1 = t_req[1] && (!m_locked || m_owner == 1);
        if (el0 && el1) win = m_prio;
        else if (el0)   win = 0;
        else if (el1)   win = 1;
        else            win = -1;
        al = 1'b0; w_w = 1'b0; lk_w = 1'b0; a_w = '0; d_w = '0;
        if (win >= 0) begin
            a_w = t_addr[win]; d_w = t_wdata[win]; w_w = t_wr[win]; lk_w = t_lk[win];
            al = (a_w[1:0] == 2'b00);
        end
        acc = (win >= 0) && al;
        obs_g0 = bus.r0_gnt; obs_g1 = bus.r1_gnt; obs_mw = bus.mem_write;
        chk("r0_gnt",      32'(bus.r0_gnt),    32'(win == 0));
        chk("r1_gnt",      32'(bus.r1_gnt),    32'(win == 1));
        chk("mem_write",   32'(bus.mem_write), 32'(acc && w_w));
        chk("mem_read",    32'(bus.mem_read),  32'(acc && !w_w));
        chk("mem_address", bus.mem_address,    acc ? a_w : 32'h0);
        chk("mem_wdata",   bus.mem_write_data, acc ? d_w : 32'h0);
        @(posedge clk);
        e_rv = '{0, 0}; e_er = '{0, 0}; e_rd = '{32'h0, 32'h0};
        if (win >= 0) begin
            if (al) begin
                e_rv[win] = 1'b1;
                if (w_w) ref_mem[a_w[9:2]] = d_w;
                else     e_rd[win] = ref_mem[a_w[9:2]];
            end else begin
                e_er[win] = 1'b1;
            end
        end
        if (reset) begin
            e_rv = '{0, 0}; e_er = '{0, 0};
            m_locked = 1'b0; m_owner = 0; m_prio = 0; m_idle = 0;
        end else if (!m_locked) begin
            if (win >= 0) begin
                m_prio = 1 - win;
                if (al && lk_w) begin
                    m_locked = 1'b1; m_owner = win; m_idle = 0;
                end
            end
        end else begin
            if (win == m_owner && al && !lk_w) begin
                m_locked = 1'b0; m_prio = 1 - m_owner; m_idle = 0;
            end else if (t_req[m_owner]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_locked = 1'b0; m_prio = 1 - m_owner; m_idle = 0;
                end
            end
        end
        #1;
        chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(e_rv[0]));
        chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(e_rv[1]));
        chk("r0_err",    32'(bus.r0_err),    32'(e_er[0]));
        chk("r1_err",    32'(bus.r1_err),    32'(e_er[1]));
        if (e_rv[0]) chk("r0_rdata", bus.r0_rdata, e_rd[0]);
        if (e_rv[1]) chk("r1_rdata", bus.r1_rdata, e_rd[1]);
        last_win = win;
        @(negedge clk);
    endtask

    task automatic idle_all();
        setp(0, 0, 0, 0, 32'h0, 32'h0);
        setp(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic reset_cycle();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    bit pend [2];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_locked = 1'b0; m_owner = 0; m_prio = 0; m_idle = 0;
        idle_all();
        apply();
        reset = 1'b1;
        mem_clear = 1'b1;
        @(negedge clk);
        step();
        step();
        mem_clear = 1'b0;
        reset = 1'b0;
        chk("reset_r0_rvalid", 32'(bus.r0_rvalid), 32'h0);
        chk("reset_r1_err",    32'(bus.r1_err),    32'h0);
        chk("reset_r0_rdata",  bus.r0_rdata,       32'h0);

        // Single load of a freshly stored word
        setp(0, 1, 1, 0, 32'h14, 32'hDEADBEEF); step();
        setp(0, 1, 0, 0, 32'h14, 32'h0);        step();
        chk("single_gnt",    32'(obs_g0),        32'h1);
        chk("single_rvalid", 32'(bus.r0_rvalid), 32'h1);
        chk("single_rdata",  bus.r0_rdata,       32'hDEADBEEF);
        idle_all(); step();

        // Contention from reset: grants alternate starting with port 0
        reset_cycle();
        for (int i = 0; i < 6; i++) begin
            setp(0, 1, 0, 0, 32'(i * 4), 32'h0);
            setp(1, 1, 0, 0, 32'(i * 4 + 64), 32'h0);
            step();
            chk("cont_g0",   32'(obs_g0), 32'(i % 2 == 0));
            chk("cont_g1",   32'(obs_g1), 32'(i % 2 == 1));
            chk("cont_both", 32'(obs_g0 & obs_g1), 32'h0);
        end

        // Locked read-modify-write by port 1 stalls port 0
        reset_cycle();
        setp(1, 1, 1, 1, 32'h40, 32'hA5A5A5A5); step();
        chk("lock_g1_a", 32'(obs_g1), 32'h1);
        setp(0, 1, 0, 0, 32'h44, 32'h0);
        setp(1, 1, 0, 1, 32'h40, 32'h0); step();
        chk("lock_g0_b", 32'(obs_g0), 32'h0);
        chk("lock_rd_b", bus.r1_rdata, 32'hA5A5A5A5);
        setp(1, 1, 1, 0, 32'h40, 32'h5A5A5A5A); step();
        chk("lock_g0_c", 32'(obs_g0), 32'h0);
        chk("lock_g1_c", 32'(obs_g1), 32'h1);
        setp(1, 0, 0, 0, 32'h0, 32'h0); step();
        chk("lock_g0_release", 32'(obs_g0), 32'h1);
        idle_all(); step();

        // Lock timeout: owner goes idle, other port waits exactly TO cycles
        reset_cycle();
        setp(0, 1, 0, 1, 32'h8, 32'h0); step();
        chk("to_lock_g0", 32'(obs_g0), 32'h1);
        setp(0, 0, 0, 0, 32'h0, 32'h0);
        setp(1, 1, 0, 0, 32'h8, 32'h0);
        for (int i = 0; i < TO + 1; i++) begin
            step();
            chk("to_g1", 32'(obs_g1), 32'(i == TO));
        end
        idle_all(); step();

        // Misaligned store: granted, no memory access, error pulse
        setp(0, 1, 1, 0, 32'h10, 32'h11111111); step();
        setp(0, 1, 1, 0, 32'h13, 32'hBAD0BAD0); step();
        chk("mis_gnt",  32'(obs_g0),     32'h1);
        chk("mis_mw",   32'(obs_mw),     32'h0);
        chk("mis_err",  32'(bus.r0_err), 32'h1);
        idle_all(); step();
        chk("mis_mem",  mem[4],          32'h11111111);

        // Reset in the same cycle as a locking grant: no response, no lock
        reset = 1'b1;
        setp(0, 1, 0, 1, 32'h14, 32'h0); step();
        reset = 1'b0;
        chk("rstgnt_rvalid", 32'(bus.r0_rvalid), 32'h0);
        setp(0, 0, 0, 0, 32'h0, 32'h0);
        setp(1, 1, 0, 0, 32'h20, 32'h0); step();
        chk("rstgnt_nolock", 32'(obs_g1), 32'h1);
        idle_all(); step();

        // Reset in the cycle after a locking grant clears lock and priority
        setp(0, 1, 0, 1, 32'h14, 32'h0); step();
        idle_all();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rstmid_rvalid", 32'(bus.r0_rvalid), 32'h0);
        setp(0, 1, 0, 0, 32'h18, 32'h0);
        setp(1, 1, 0, 0, 32'h1C, 32'h0); step();
        chk("rstmid_prio", 32'(obs_g0), 32'h1);
        idle_all(); step();

        // Random traffic with holds, withdrawals, locks and occasional resets
        pend = '{0, 0};
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if ($urandom_range(2) != 0) begin
                        logic [31:0] a;
                        a = {26'h0, 4'($urandom_range(15)), 2'b00};
                        if ($urandom_range(15) == 0) a[1:0] = 2'($urandom_range(3));
                        setp(n, 1, 1'($urandom_range(1)), ($urandom_range(5) == 0),
                             a, $urandom);
                        pend[n] = 1'b1;
                    end else begin
                        setp(n, 0, 0, 0, 32'h0, 32'h0);
                    end
                end else if ($urandom_range(19) == 0) begin
                    pend[n] = 1'b0;
                    t_req[n] = 1'b0;
                end
            end
            reset = ($urandom_range(99) == 0);
            step();
            reset = 1'b0;
            if (last_win >= 0) begin
                pend[last_win] = 1'b0;
                t_req[last_win] = 1'b0;
            end
        end
        idle_all(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
